// File: rtl/muldiv_sequencer.sv
// RV32 M-extension sequencer: fixed-latency multiply and iterative restoring divide
// with BUSY stall, FLUSH abort and a registered one-cycle DONE pulse.
module muldiv_sequencer #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned MUL_LATENCY = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] DATA1,
   input  logic [XLEN-1:0] DATA2,
   input  logic            FLUSH,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   localparam int unsigned CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(XLEN - 2);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
   localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_fn;
   logic [XLEN-1:0]   r_op1, r_op2;
   logic [XLEN-1:0]   r_rem, r_quo, r_dvs;
   logic              r_neg_q, r_neg_r, r_special;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_accept, w_done_nxt, w_res_load;
   logic [XLEN-1:0]   w_res_nxt;

   // multiply datapath (operands come straight from the ports only for single-cycle latency)
   logic [1:0]        w_fn;
   logic [XLEN-1:0]   w_ma, w_mb;
   logic              w_sa, w_sb;
   logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
   logic [XLEN-1:0]   w_mul_res;

   assign w_fn      = (r_state == S_IDLE) ? FUNCT3[1:0] : r_fn;
   assign w_ma      = (r_state == S_IDLE) ? DATA1 : r_op1;
   assign w_mb      = (r_state == S_IDLE) ? DATA2 : r_op2;
   assign w_sa      = (w_fn != 2'b11);
   assign w_sb      = ~w_fn[1];
   assign w_ext_a   = {{XLEN{w_sa & w_ma[XLEN-1]}}, w_ma};
   assign w_ext_b   = {{XLEN{w_sb & w_mb[XLEN-1]}}, w_mb};
   assign w_prod    = w_ext_a * w_ext_b;
   assign w_mul_res = (w_fn == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // divide operand conditioning and special-case detection at accept
   logic              w_d_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;

   assign w_d_signed = ~FUNCT3[0];
   assign w_a_neg    = w_d_signed & DATA1[XLEN-1];
   assign w_b_neg    = w_d_signed & DATA2[XLEN-1];
   assign w_a_mag    = w_a_neg ? -DATA1 : DATA1;
   assign w_b_mag    = w_b_neg ? -DATA2 : DATA2;
   assign w_div0     = (DATA2 == '0);
   assign w_ovf      = w_d_signed & (DATA1 == MIN_NEG) & (DATA2 == '1);
   assign w_special  = FUNCT3[2] & (w_div0 | w_ovf);
   assign w_spec_res = FUNCT3[1] ? (w_div0 ? DATA1 : '0) : (w_div0 ? '1 : DATA1);

   // One restoring step; the first of the XLEN steps runs on the accept edge
   // so that DIV needs only XLEN-1 further cycles before FIX.
   logic [XLEN-1:0]   w_src_rem, w_src_quo, w_src_dvs;
   logic [XLEN:0]     w_shift, w_trial;
   logic [XLEN-1:0]   w_step_rem, w_step_quo;

   assign w_src_rem  = (r_state == S_IDLE) ? '0 : r_rem;
   assign w_src_quo  = (r_state == S_IDLE) ? w_a_mag : r_quo;
   assign w_src_dvs  = (r_state == S_IDLE) ? w_b_mag : r_dvs;
   assign w_shift    = {w_src_rem, w_src_quo[XLEN-1]};
   assign w_trial    = w_shift - {1'b0, w_src_dvs};
   assign w_step_rem = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
   assign w_step_quo = {w_src_quo[XLEN-2:0], ~w_trial[XLEN]};

   logic [XLEN-1:0]   w_q_fix, w_r_fix, w_fix_res;

   assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
   assign w_fix_res = r_special ? r_quo : (r_fn[1] ? w_r_fix : w_q_fix);

   assign w_accept  = START & ~FLUSH & (r_state == S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_res_load  = 1'b0;
      w_res_nxt   = w_mul_res;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (FUNCT3[2]) begin
                  w_state_nxt = w_special ? S_FIX : S_DIV;
               end else if (MUL_LATENCY == 1) begin
                  w_done_nxt = 1'b1;
                  w_res_load = 1'b1;
               end else begin
                  w_state_nxt = S_MUL;
               end
            end
         end
         S_MUL: begin
            if (FLUSH) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
               w_res_load  = 1'b1;
            end
         end
         S_DIV: begin
            if (FLUSH) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            w_state_nxt = S_IDLE;
            if (!FLUSH) begin
               w_done_nxt = 1'b1;
               w_res_load = 1'b1;
               w_res_nxt  = w_fix_res;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= w_done_nxt;
         if (w_res_load) begin
            r_result <= w_res_nxt;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_cnt     <= '0;
         r_fn      <= '0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_special <= 1'b0;
      end else if (w_accept) begin
         r_fn      <= FUNCT3[1:0];
         r_op1     <= DATA1;
         r_op2     <= DATA2;
         r_dvs     <= w_b_mag;
         r_neg_q   <= w_a_neg ^ w_b_neg;
         r_neg_r   <= w_a_neg;
         r_special <= w_special;
         r_cnt     <= FUNCT3[2] ? DIV_CNT : MUL_CNT;
         if (w_special) begin
            r_rem <= '0;
            r_quo <= w_spec_res;
         end else begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
         end
      end else if (r_state == S_DIV && !FLUSH) begin
         r_rem <= w_step_rem;
         r_quo <= w_step_quo;
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end else if (r_state == S_MUL && !FLUSH && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign BUSY   = (r_state != S_IDLE);
   assign DONE   = r_done;
   assign RESULT = r_result;

endmodule
